// File: rtl/alu_seq_ctrl.sv
// Issue/writeback sequencer for the external 8-bit combinational ALU.
// Handles one instruction at a time: IDLE (accept) -> EXEC (drive ALU, write back) -> RESP (hold result).
module alu_seq_ctrl #(
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   instr,
    output logic [DW-1:0] n1,
    output logic [DW-1:0] n2,
    output logic [3:0]    op,
    input  logic [DW-1:0] s1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic [2:0]    rd_out,
    output logic          zero,
    output logic          neg
);

    localparam logic [3:0] OP_LOADI = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   ir;
    logic [DW-1:0] regs [1:7];
    logic [3:0]    ir_op;
    logic [2:0]    ir_rd, ir_rs1, ir_rs2;
    logic [DW-1:0] ra, rb, wb;
    logic          is_loadi;

    function automatic logic flag_zero(input logic [DW-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic flag_neg(input logic [DW-1:0] v);
        logic signed [DW-1:0] sv;
        sv = signed'(v);
        return (sv < 0);
    endfunction

    assign ir_op    = ir[15:12];
    assign ir_rd    = ir[11:9];
    assign ir_rs1   = ir[8:6];
    assign ir_rs2   = ir[5:3];
    assign is_loadi = (ir_op == OP_LOADI);
    assign wb       = is_loadi ? ir[7:0] : s1;

    // r0 has no storage: it reads as zero and its writes are dropped
    always_comb begin
        ra = '0;
        rb = '0;
        for (int i = 1; i < 8; i++) begin
            if (ir_rs1 == 3'(i)) ra = regs[i];
            if (ir_rs2 == 3'(i)) rb = regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == RESP);
        n1        = '0;
        n2        = '0;
        op        = 4'b0000;
        if (state == EXEC) begin
            n1 = ra;
            n2 = rb;
            op = is_loadi ? 4'b0000 : ir_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= '0;
        end else if (state == IDLE && in_valid) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 8; i++) regs[i] <= RST_VAL;
        end else if (state == EXEC) begin
            for (int i = 1; i < 8; i++) begin
                if (ir_rd == 3'(i)) regs[i] <= wb;
            end
        end
    end

    // Result and flags are captured once in EXEC and held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            rd_out <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else if (state == EXEC) begin
            result <= wb;
            rd_out <= ir_rd;
            zero   <= flag_zero(wb);
            neg    <= flag_neg(wb);
        end
    end

endmodule
